// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared types and helpers for the multi-channel integrity scoreboard
package sb_pkg;

    localparam int SB_STATE_W = 2;

    typedef enum logic [SB_STATE_W-1:0] {
        SB_IDLE  = 2'd0,
        SB_TRACK = 2'd1,
        SB_DONE  = 2'd2
    } sb_state_e;

    // Counter width able to hold the value depth itself (full channel).
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sb_occ_counter.sv
// rtl/sb_occ_counter.sv - saturating occupancy counter for one monitored channel
module sb_occ_counter #(
    parameter int DEPTH = 8,
    parameter int CNTW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic            i_pop,
    output logic [CNTW-1:0] o_occ,
    output logic            o_push_acc,
    output logic            o_pop_acc
);

    logic [CNTW-1:0] r_occ;

    // A pop needs an entry present; a push needs room before this cycle's pop,
    // so push+pop on a full channel drains one entry.
    assign o_pop_acc  = i_pop & (r_occ != '0);
    assign o_push_acc = i_push & (r_occ < CNTW'(DEPTH));
    assign o_occ      = r_occ;

    // Occupancy follows accepted push minus accepted pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else begin
            case ({o_push_acc, o_pop_acc})
                2'b10:   r_occ <= r_occ + CNTW'(1);
                2'b01:   r_occ <= r_occ - CNTW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/multi_channel_integrity_scoreboard.sv
// rtl/multi_channel_integrity_scoreboard.sv - magic-packet integrity monitor over NUM_CH channels (option: MULTI_SHOT_EN)
module multi_channel_integrity_scoreboard
    import sb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CNTW   = cnt_width(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        push,
    input  logic [NUM_CH-1:0]        pop,
    input  logic [NUM_CH*WIDTH-1:0]  flat_data_in,
    input  logic [NUM_CH*WIDTH-1:0]  flat_data_out,
    input  logic                     start,
    input  logic [CHW-1:0]           sel_ch,
    output logic                     data_out_vld,
    output logic                     prop_signal,
    output logic                     fail,
    output logic [SB_STATE_W-1:0]    state,
    output logic [NUM_CH*CNTW-1:0]   occ
`ifdef MULTI_SHOT_EN
    ,
    output logic [15:0]              checks
`endif
);

    logic [NUM_CH-1:0]       w_push_acc;
    logic [NUM_CH-1:0]       w_pop_acc;
    logic [NUM_CH*CNTW-1:0]  w_occ;

    sb_state_e               r_state;
    logic [CNTW-1:0]         r_cnt;
    logic [WIDTH-1:0]        r_magic;
    logic [CHW-1:0]          r_mch;
    logic                    r_fail;
`ifdef MULTI_SHOT_EN
    logic [15:0]             r_checks;
`endif

    logic                    w_sel_ok;
    logic                    w_sel_push;
    logic                    w_sel_pop;
    logic [CNTW-1:0]         w_sel_occ;
    logic [WIDTH-1:0]        w_sel_din;
    logic                    w_m_pop;
    logic [WIDTH-1:0]        w_m_dout;
    logic                    w_capture;
    logic                    w_exit;
    logic                    w_match;
    logic [CNTW-1:0]         w_cap_cnt;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            sb_occ_counter #(
                .DEPTH (DEPTH),
                .CNTW  (CNTW)
            ) u_occ (
                .clk        (clk),
                .rst        (rst),
                .i_push     (push[g]),
                .i_pop      (pop[g]),
                .o_occ      (w_occ[g*CNTW +: CNTW]),
                .o_push_acc (w_push_acc[g]),
                .o_pop_acc  (w_pop_acc[g])
            );
        end
    endgenerate

    // Per-channel views of the selected channel (capture side) and the
    // tracked channel (exit side); an out-of-range sel_ch matches nothing.
    always_comb begin
        w_sel_ok   = 1'b0;
        w_sel_push = 1'b0;
        w_sel_pop  = 1'b0;
        w_sel_occ  = '0;
        w_sel_din  = '0;
        w_m_pop    = 1'b0;
        w_m_dout   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_ch == CHW'(i)) begin
                w_sel_ok   = 1'b1;
                w_sel_push = w_push_acc[i];
                w_sel_pop  = w_pop_acc[i];
                w_sel_occ  = w_occ[i*CNTW +: CNTW];
                w_sel_din  = flat_data_in[i*WIDTH +: WIDTH];
            end
            if (r_mch == CHW'(i)) begin
                w_m_pop  = w_pop_acc[i];
                w_m_dout = flat_data_out[i*WIDTH +: WIDTH];
            end
        end
    end

    // The magic entry sits behind everything already queued, less any entry
    // leaving in the capture cycle itself.
    assign w_cap_cnt = w_sel_occ + CNTW'(1) - CNTW'(w_sel_pop);
    assign w_capture = (r_state == SB_IDLE) & start & w_sel_ok & w_sel_push;
    assign w_exit    = (r_state == SB_TRACK) & w_m_pop & (r_cnt == CNTW'(1));
    assign w_match   = (r_magic == w_m_dout);

    assign data_out_vld = w_exit;
    assign prop_signal  = ~w_exit | w_match;
    assign fail         = r_fail;
    assign state        = r_state;
    assign occ          = w_occ;
`ifdef MULTI_SHOT_EN
    assign checks       = r_checks;
`endif

    // Capture / track / done sequencing with magic, position and sticky fail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= SB_IDLE;
            r_cnt    <= '0;
            r_magic  <= '0;
            r_mch    <= '0;
            r_fail   <= 1'b0;
`ifdef MULTI_SHOT_EN
            r_checks <= '0;
`endif
        end else begin
            case (r_state)
                SB_IDLE: begin
                    if (w_capture) begin
                        r_state <= SB_TRACK;
                        r_mch   <= sel_ch;
                        r_magic <= w_sel_din;
                        r_cnt   <= w_cap_cnt;
                    end
                end
                SB_TRACK: begin
                    if (w_exit) begin
                        r_state <= SB_DONE;
                        r_cnt   <= '0;
                        if (!w_match) begin
                            r_fail <= 1'b1;
                        end
`ifdef MULTI_SHOT_EN
                        if (r_checks != 16'hFFFF) begin
                            r_checks <= r_checks + 16'd1;
                        end
`endif
                    end else if (w_m_pop) begin
                        r_cnt <= r_cnt - CNTW'(1);
                    end
                end
                SB_DONE: begin
                    r_cnt <= '0;
`ifdef MULTI_SHOT_EN
                    r_state <= SB_IDLE;
`endif
                end
                default: begin
                    r_state <= SB_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_channel_integrity_scoreboard.sv
// tb/tb_multi_channel_integrity_scoreboard.sv - randomized and directed bench with a queue-based reference model
module tb_multi_channel_integrity_scoreboard;

    localparam int NCH = 4;
    localparam int DEP = 8;
    localparam int W   = 8;
    localparam int CW  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    push;
    logic [NCH-1:0]    pop;
    logic [NCH*W-1:0]  flat_data_in;
    logic [NCH*W-1:0]  flat_data_out;
    logic              start;
    logic [1:0]        sel_ch;
    logic              data_out_vld;
    logic              prop_signal;
    logic              fail;
    logic [1:0]        state;
    logic [NCH*CW-1:0] occ;
`ifdef MULTI_SHOT_EN
    logic [15:0]       checks;
`endif

    always #5 clk = ~clk;

    multi_channel_integrity_scoreboard #(
        .NUM_CH (NCH),
        .DEPTH  (DEP),
        .WIDTH  (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .pop           (pop),
        .flat_data_in  (flat_data_in),
        .flat_data_out (flat_data_out),
        .start         (start),
        .sel_ch        (sel_ch),
        .data_out_vld  (data_out_vld),
        .prop_signal   (prop_signal),
        .fail          (fail),
        .state         (state),
        .occ           (occ)
`ifdef MULTI_SHOT_EN
        ,
        .checks        (checks)
`endif
    );

    // Reference: each channel is a real FIFO of entries, one of which may be
    // flagged as the magic packet; its exit is seen when it reaches the head.
    typedef struct packed {
        logic [7:0] d;
        logic       m;
    } ent_t;

    ent_t       mq[NCH][$];
    int         m_phase;
    int         m_ch;
    logic [7:0] m_magic;
    logic       m_fail;
    int         m_checks;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) mq[i].delete();
        m_phase  = 0;
        m_ch     = 0;
        m_magic  = 8'h00;
        m_fail   = 1'b0;
        m_checks = 0;
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, ".state"}, 32'(state), 32'(m_phase));
        check_eq({tag, ".fail"}, 32'(fail), 32'(m_fail));
        for (int i = 0; i < NCH; i++)
            check_eq($sformatf("%s.occ%0d", tag, i), 32'(occ[i*CW +: CW]), 32'(mq[i].size()));
`ifdef MULTI_SHOT_EN
        check_eq({tag, ".checks"}, 32'(checks), 32'(m_checks));
`endif
    endtask

    // Reset asserted between clock edges; its effect must be immediate.
    task automatic do_reset(input string tag);
        @(negedge clk);
        push  = '0;
        pop   = '0;
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_clear();
        check_regs({tag, ".rst"});
        check_eq({tag, ".rst.vld"}, 32'(data_out_vld), 32'd0);
        check_eq({tag, ".rst.prop"}, 32'(prop_signal), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock of stimulus: check registered outputs, drive, check the
    // combinational outputs, advance the model over the coming edge.
    task automatic step(input string tag, input logic [3:0] pu, input logic [3:0] po,
                        input logic [31:0] din, input logic st, input logic [1:0] sel,
                        input logic [3:0] corrupt);
        logic [7:0] dv[NCH];
        logic [3:0] pa, ua;
        logic       exp_vld, exp_prop, cap;
        ent_t       e;
        @(negedge clk);
        check_regs(tag);
        for (int i = 0; i < NCH; i++) begin
            dv[i] = (mq[i].size() > 0) ? mq[i][0].d : 8'($urandom);
            if (corrupt[i]) dv[i] = dv[i] ^ 8'h01;
            flat_data_out[i*W +: W] = dv[i];
            pa[i] = po[i] && (mq[i].size() > 0);
            ua[i] = pu[i] && (mq[i].size() < DEP);
        end
        push         = pu;
        pop          = po;
        flat_data_in = din;
        start        = st;
        sel_ch       = sel;
        exp_vld = 1'b0;
        if (m_phase == 1 && pa[m_ch]) exp_vld = mq[m_ch][0].m;
        exp_prop = !exp_vld || (dv[m_ch] == m_magic);
        #1;
        check_eq({tag, ".vld"}, 32'(data_out_vld), 32'(exp_vld));
        check_eq({tag, ".prop"}, 32'(prop_signal), 32'(exp_prop));
        cap = (m_phase == 0) && st && ua[sel];
        for (int i = 0; i < NCH; i++) begin
            if (pa[i]) void'(mq[i].pop_front());
            if (ua[i]) begin
                e.d = din[i*8 +: 8];
                e.m = cap && (i == int'(sel));
                mq[i].push_back(e);
            end
        end
        if (cap) begin
            m_phase = 1;
            m_ch    = int'(sel);
            m_magic = din[sel*8 +: 8];
        end else if (exp_vld) begin
            m_phase = 2;
            if (!exp_prop) m_fail = 1'b1;
            if (m_checks < 65535) m_checks++;
        end else if (m_phase == 2) begin
`ifdef MULTI_SHOT_EN
            m_phase = 0;
`endif
        end
        @(posedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        push          = '0;
        pop           = '0;
        start         = 1'b0;
        sel_ch        = '0;
        flat_data_in  = '0;
        flat_data_out = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_regs("por");
        check_eq("por.vld", 32'(data_out_vld), 32'd0);
        check_eq("por.prop", 32'(prop_signal), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Basic exit on ch0 behind three entries.
        do_reset("basic");
        step("basic.p0", 4'b0001, 4'b0000, 32'h11, 1'b0, 2'd0, 4'h0);
        step("basic.p1", 4'b0001, 4'b0000, 32'h22, 1'b0, 2'd0, 4'h0);
        step("basic.p2", 4'b0001, 4'b0000, 32'h33, 1'b0, 2'd0, 4'h0);
        step("basic.cap", 4'b0001, 4'b0000, 32'h5A, 1'b1, 2'd0, 4'h0);
        for (int k = 0; k < 4; k++) step($sformatf("basic.pop%0d", k), 4'b0000, 4'b0001, 32'h0, 1'b0, 2'd0, 4'h0);
        step("basic.end", 4'b0000, 4'b0000, 32'h0, 1'b1, 2'd0, 4'h0);
        step("basic.end2", 4'b0000, 4'b0000, 32'h0, 1'b0, 2'd0, 4'h0);

        // Same sequence, exiting data corrupted to 0x5B.
        do_reset("mism");
        step("mism.p0", 4'b0001, 4'b0000, 32'h11, 1'b0, 2'd0, 4'h0);
        step("mism.p1", 4'b0001, 4'b0000, 32'h22, 1'b0, 2'd0, 4'h0);
        step("mism.p2", 4'b0001, 4'b0000, 32'h33, 1'b0, 2'd0, 4'h0);
        step("mism.cap", 4'b0001, 4'b0000, 32'h5A, 1'b1, 2'd0, 4'h0);
        for (int k = 0; k < 3; k++) step($sformatf("mism.pop%0d", k), 4'b0000, 4'b0001, 32'h0, 1'b0, 2'd0, 4'h0);
        step("mism.exit", 4'b0000, 4'b0001, 32'h0, 1'b0, 2'd0, 4'h1);
        step("mism.hold", 4'b0000, 4'b0000, 32'h0, 1'b0, 2'd0, 4'h0);
        step("mism.hold2", 4'b0000, 4'b0000, 32'h0, 1'b0, 2'd0, 4'h0);

        // Capture with a simultaneous pop on ch2.
        do_reset("cpop");
        for (int k = 0; k < 3; k++) step($sformatf("cpop.p%0d", k), 4'b0100, 4'b0000, 32'h00400000 + 32'(k << 16), 1'b0, 2'd0, 4'h0);
        step("cpop.cap", 4'b0100, 4'b0100, 32'h00C30000, 1'b1, 2'd2, 4'h0);
        for (int k = 0; k < 3; k++) step($sformatf("cpop.pop%0d", k), 4'b0000, 4'b0100, 32'h0, 1'b0, 2'd0, 4'h0);
        step("cpop.end", 4'b0000, 4'b0000, 32'h0, 1'b0, 2'd0, 4'h0);

        // Full boundary on ch1.
        do_reset("full");
        for (int k = 0; k < DEP; k++) step($sformatf("full.p%0d", k), 4'b0010, 4'b0000, 32'(k << 8), 1'b0, 2'd0, 4'h0);
        step("full.cap", 4'b0010, 4'b0000, 32'h0000EE00, 1'b1, 2'd1, 4'h0);
        step("full.pp", 4'b0010, 4'b0010, 32'h0000DD00, 1'b0, 2'd0, 4'h0);
        step("full.end", 4'b0000, 4'b0000, 32'h0, 1'b0, 2'd0, 4'h0);

        // Reset in the middle of tracking; no exit without a new capture.
        do_reset("art");
        step("art.p0", 4'b0001, 4'b0000, 32'h01, 1'b0, 2'd0, 4'h0);
        step("art.cap", 4'b0001, 4'b0000, 32'h77, 1'b1, 2'd0, 4'h0);
        step("art.pop", 4'b0000, 4'b0001, 32'h0, 1'b0, 2'd0, 4'h0);
        do_reset("art2");
        step("art2.p0", 4'b0001, 4'b0000, 32'h77, 1'b0, 2'd0, 4'h0);
        for (int k = 0; k < 3; k++) step($sformatf("art2.pop%0d", k), 4'b0000, 4'b0001, 32'h0, 1'b0, 2'd0, 4'h0);

        // Two back-to-back shots on ch3.
        do_reset("shot");
        for (int s = 0; s < 2; s++) begin
            step($sformatf("shot%0d.cap", s), 4'b1000, 4'b0000, 32'(8'hA0 + s) << 24, 1'b1, 2'd3, 4'h0);
            step($sformatf("shot%0d.pop", s), 4'b0000, 4'b1000, 32'h0, 1'b0, 2'd0, 4'h0);
            step($sformatf("shot%0d.idle", s), 4'b0000, 4'b0000, 32'h0, 1'b0, 2'd0, 4'h0);
        end
        step("shot.end", 4'b0000, 4'b0000, 32'h0, 1'b0, 2'd0, 4'h0);
`ifdef MULTI_SHOT_EN
        check_eq("shot.checks2", 32'(checks), 32'd2);
`endif

        // Randomized traffic, reset between batches.
        for (int b = 0; b < 20; b++) begin
            do_reset($sformatf("rnd%0d", b));
            for (int k = 0; k < 150; k++) begin
                step($sformatf("rnd%0d.%0d", b, k),
                     4'($urandom) & 4'($urandom) | ((b % 2 == 0) ? 4'($urandom) & 4'($urandom) : 4'h0),
                     4'($urandom) & 4'($urandom),
                     $urandom,
                     ($urandom_range(0, 9) == 0),
                     2'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) == 0) ? 4'hF : 4'h0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_channel_integrity_scoreboard.md
Name: multi_channel_integrity_scoreboard

Overview:
- Parametrised successor to the single-magic-packet scoreboard. Passively monitors NUM_CH FIFO-like channels.
- Per channel: tracks occupancy. On request, captures one "magic" packet on a runtime-selected channel and follows it to the head.
- When the magic packet exits, compares the exiting data against the captured value.
- Sits beside the DUT in formal/simulation harnesses. Drives a prop_signal for assertions and a sticky fail flag.

Parameters:
- NUM_CH, 4, number of monitored channels (≥1).
- DEPTH, 8, capacity of each monitored channel in entries (≥1).
- WIDTH, 8, packet data width in bits.
- CHW, $clog2(NUM_CH) (min 1), channel-select width.
- CNTW, $clog2(DEPTH+1), counter width. Must hold the value DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- push  in  NUM_CH  per-channel enqueue strobe.
- pop  in  NUM_CH  per-channel dequeue strobe.
- flat_data_in  in  NUM_CH*WIDTH  enqueue data; channel i occupies bits [(i+1)*WIDTH-1 : i*WIDTH].
- flat_data_out  in  NUM_CH*WIDTH  head data of each channel, valid in the cycle its pop is high.
- start  in  1  request capture of the next accepted push on sel_ch.
- sel_ch  in  CHW  channel to capture on; sampled only at capture.
- data_out_vld  out  1  magic packet leaving in this cycle.
- prop_signal  out  1  ~data_out_vld | (magic == exiting data).
- fail  out  1  sticky: a mismatch has occurred.
- state  out  2  current FSM state.
- occ  out  NUM_CH*CNTW  per-channel occupancy, registered.

Behaviour:
- Reset (async assert, synchronous deassert by next edge): state=IDLE, all occ=0, cnt=0, magic=0, mch=0, fail=0. data_out_vld=0. prop_signal=1.
- Push acceptance: accepted on channel i only when occ[i] < DEPTH. Pushes to a full channel are ignored.
- Pop acceptance: accepted only when occ[i] > 0. Pops from an empty channel are ignored (no bypass).
- Occupancy update: occ[i] += accepted push − accepted pop, every cycle, in all states.
- Simultaneous push+pop on a full channel: the pop is accepted and the push is rejected, so occ becomes DEPTH−1.
- FSM states: IDLE(0), TRACK(1), DONE(2). Encoding 3 is unreachable and recovers to IDLE.
- IDLE → TRACK: when start is high and a push on channel sel_ch is accepted.
  - Latch mch=sel_ch and magic = data_in[sel_ch].
  - cnt = occ[sel_ch] + 1 − (accepted pop on sel_ch). cnt is ≥1.
  - sel_ch ≥ NUM_CH: capture suppressed, stay IDLE.
- TRACK:
  - Each accepted pop on mch decrements cnt. Pushes after capture do not affect cnt.
  - The accepted pop with cnt==1 is the exit cycle. data_out_vld=1 combinationally in that cycle.
  - Compare against data_out[mch]. On mismatch, fail←1 at the next edge. Next state: DONE.
- DONE: terminal until reset. cnt=0, data_out_vld=0.
- Latency: data_out_vld asserts in the same cycle as the exiting pop. fail asserts one cycle later.
- prop_signal is combinational. It is 1 whenever data_out_vld=0.
- start while in TRACK or DONE is ignored.
- Counter arithmetic is CNTW bits with saturating guards: occ never exceeds DEPTH and never goes below 0.

Optional Feature:
- MULTI_SHOT_EN defined:
  - DONE returns to IDLE on the following cycle, so repeated captures are allowed.
  - An extra output, checks [15:0], counts completed comparisons and saturates at 16'hFFFF.
  - fail remains sticky across shots.
- MULTI_SHOT_EN undefined: DONE is terminal and the checks port does not exist.

Decomposition:
- Package sb_pkg:
  - state enum (SB_IDLE, SB_TRACK, SB_DONE).
  - function cnt_width(depth) returning $clog2(depth+1).
  - state width constant.
- One sub-module: sb_occ_counter.
  - Per-channel saturating occupancy counter.
  - Outputs occ, push_acc and pop_acc.
  - Instantiated NUM_CH times in a generate loop.
- The top level holds the FSM, magic/mch/cnt registers, the comparator and the fail flag.

Test Plan:
- Basic exit: rst, then push ch0 values 0x11, 0x22, 0x33. start+push 0x5A on ch0 (cnt=4). Pop ch0 four times with data_out 0x11, 0x22, 0x33, 0x5A → data_out_vld only on the 4th pop, prop_signal=1, fail=0, state=DONE.
- Mismatch: same sequence but data_out=0x5B on exit → prop_signal=0 in the exit cycle, fail=1 the next cycle and stays 1.
- Capture with simultaneous pop: occ[2]=3, sel_ch=2, start+push+pop on ch2 in the same cycle → cnt=3, occ[2]=3. The exit occurs on the 3rd subsequent pop.
- Full boundary (DEPTH=8): fill ch1 to 8. start+push on ch1 → no capture, state=IDLE, occ=8. Push+pop on full ch1 → occ=7.
- Async reset mid-TRACK: assert rst between edges → state=IDLE, occ=0 and fail=0 immediately. No data_out_vld afterwards without a new capture.
- MULTI_SHOT_EN: two back-to-back captures on ch3 with a match each → checks=2, and state returns to IDLE after each DONE.
